// File: rtl/mc_pkg.sv
// Shared types and defaults for the memory arbiter slice.
package mc_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle of the arbiter; master = environment side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned AW = mc_pkg::DEF_AW,
  parameter int unsigned DW = mc_pkg::DEF_DW
);

  logic          CpuReq;
  logic          CpuWe;
  logic [AW-1:0] CpuAddr;
  logic [DW-1:0] CpuWData;
  logic [DW-1:0] CpuRData;
  logic          CpuAck;

  logic          DmaReq;
  logic          DmaWe;
  logic [AW-1:0] DmaAddr;
  logic [DW-1:0] DmaWData;
  logic [DW-1:0] DmaRData;
  logic          DmaAck;

  logic          MemEn;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;
  logic          Owner;

  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    input  CpuRData, CpuAck,
    output DmaReq, DmaWe, DmaAddr, DmaWData,
    input  DmaRData, DmaAck,
    input  MemEn, MemWe, MemAddr, MemWData, Owner,
    output MemRData
  );

  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    output CpuRData, CpuAck,
    input  DmaReq, DmaWe, DmaAddr, DmaWData,
    output DmaRData, DmaAck,
    output MemEn, MemWe, MemAddr, MemWData, Owner,
    input  MemRData
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between CPU and loader. ARB_ROUND_ROBIN_EN adds the last-served flop;
// otherwise the CPU has fixed priority.
module mem_arb_pick
  import mc_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_grant,
`endif
  input  logic    i_cpu_req,
  input  logic    i_dma_req,
  output req_id_t o_winner
);

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t r_last;

  // Starts as loader so the CPU wins the first contended grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= REQ_DMA;
    end else if (i_grant) begin
      r_last <= o_winner;
    end
  end

  always_comb begin
    if (i_cpu_req && i_dma_req) begin
      o_winner = (r_last == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end else if (i_dma_req) begin
      o_winner = REQ_DMA;
    end else begin
      o_winner = REQ_CPU;
    end
  end
`else
  assign o_winner = (!i_cpu_req && i_dma_req) ? REQ_DMA : REQ_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter (IDLE -> ACCESS x MEM_LAT -> RESP).
// ARB_ROUND_ROBIN_EN selects round-robin instead of fixed CPU priority.
module mem_arbiter
  import mc_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t        r_state, w_state_next;
  logic [3:0]    r_cnt;
  req_id_t       r_owner, w_winner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          w_grant;
  logic          w_last;

  assign w_grant = (r_state == IDLE) && (bus.CpuReq || bus.DmaReq);
  assign w_last  = (r_state == ACCESS) && (r_cnt == 4'd1);

  mem_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_grant   (w_grant),
`endif
    .i_cpu_req (bus.CpuReq),
    .i_dma_req (bus.DmaReq),
    .o_winner  (w_winner)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_state_next = ACCESS;
      ACCESS:  if (w_last)  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.MemEn  = 1'b0;
    bus.MemWe  = 1'b0;
    bus.CpuAck = 1'b0;
    bus.DmaAck = 1'b0;
    unique case (r_state)
      ACCESS: begin
        bus.MemEn = 1'b1;
        bus.MemWe = r_we;
      end
      RESP: begin
        bus.CpuAck = (r_owner == REQ_CPU);
        bus.DmaAck = (r_owner == REQ_DMA);
      end
      default: ;
    endcase
  end

  // Request fields are latched at grant; memory-side outputs hold them until the next grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= 4'd0;
      r_owner     <= REQ_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      r_cnt   <= LAT;
      if (w_winner == REQ_CPU) begin
        r_we    <= bus.CpuWe;
        r_addr  <= bus.CpuAddr;
        r_wdata <= bus.CpuWData;
      end else begin
        r_we    <= bus.DmaWe;
        r_addr  <= bus.DmaAddr;
        r_wdata <= bus.DmaWData;
      end
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt - 4'd1;
      if (w_last && !r_we) begin
        if (r_owner == REQ_CPU) r_cpu_rdata <= bus.MemRData;
        else                    r_dma_rdata <= bus.MemRData;
      end
    end
  end

  assign bus.MemAddr  = r_addr;
  assign bus.MemWData = r_wdata;
  assign bus.Owner    = r_owner;
  assign bus.CpuRData = r_cpu_rdata;
  assign bus.DmaRData = r_dma_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits.
REQ-003 Parameter MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 CpuReq / CpuWe  input  1 / 1  multicycle-controller access request / write select.
REQ-007 CpuAddr / CpuWData  input  AW / DW  CPU address / write data.
REQ-008 CpuRData / CpuAck  output  DW / 1  CPU read data / one-cycle completion pulse.
REQ-009 DmaReq / DmaWe  input  1 / 1  loader/debug port access request / write select.
REQ-010 DmaAddr / DmaWData  input  AW / DW  loader address / write data.
REQ-011 DmaRData / DmaAck  output  DW / 1  loader read data / one-cycle completion pulse.
REQ-012 MemEn / MemWe  output  1 / 1  unified memory enable / write enable.
REQ-013 MemAddr / MemWData  output  AW / DW  memory address / write data.
REQ-014 MemRData  input  DW  memory read data, valid on the last MemEn cycle.
REQ-015 Owner  output  1  current grant holder: 0 = CPU, 1 = loader; valid while MemEn is high.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP.
REQ-017 IDLE: if any Req is high, select a winner, latch its We/Addr/WData, load the cycle counter with MEM_LAT, and go to ACCESS; otherwise stay in IDLE.
REQ-018 ACCESS: MemEn = 1; MemWe, MemAddr and MemWData driven from the latched values; the counter decrements each cycle.
REQ-019 ACCESS exit: when the counter reaches 1, capture MemRData for reads and go to RESP.
REQ-020 RESP: assert the winner's Ack for exactly one cycle, then go to IDLE.
REQ-021 Latency: a Req sampled in IDLE at edge N gives MemEn high for cycles N+1..N+MEM_LAT and Ack in cycle N+MEM_LAT+1.
REQ-022 RData on reads: holds the captured word from the Ack cycle until that requester's next read completes.
REQ-023 RData on writes: unchanged by a write.
REQ-024 Requester obligation: hold Req and the request fields stable until Ack.
REQ-025 Req still high in the cycle after Ack: treated as a new request; at most one access per 1+MEM_LAT+1 cycles.
REQ-026 Req dropped during ACCESS: the access completes and Ack still pulses.
REQ-027 Outputs outside ACCESS: MemEn = MemWe = 0; MemAddr and MemWData hold their last values.
REQ-028 Simultaneous requests in IDLE: resolved per REQ-032/033; the loser is served on its next IDLE evaluation.

Reset
REQ-029 While Reset is high, regardless of Clk: state = IDLE, counter = 0, all Ack/MemEn/MemWe/Owner = 0, RData/MemAddr/MemWData = 0, last-served flag = loader.
REQ-030 Reset mid-ACCESS: MemEn drops immediately, no Ack is issued, and the transaction is lost.
REQ-031 First IDLE evaluation after Reset release: occurs on the first rising Clk edge.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not served last; the last-served flag updates on each grant.
REQ-033 Without ARB_ROUND_ROBIN_EN: fixed priority, CPU always wins; the last-served flag is not implemented.

Structure
REQ-034 Shared package mc_pkg: state enum (IDLE, ACCESS, RESP), requester IDs (REQ_CPU = 0, REQ_DMA = 1), default AW/DW.
REQ-035 One sub-module, mem_arb_pick: takes both Req lines and last-served, and returns the winner ID; under ARB_ROUND_ROBIN_EN it contains the last-served flop.

Verification
REQ-036 MEM_LAT=2, CPU read of 0x10 with MemRData=0xDEADBEEF -> MemEn high 2 cycles, CpuAck in cycle 3, CpuRData=0xDEADBEEF.
REQ-037 Loader write of 0x20 with data 0x12345678 -> MemWe=1 and MemAddr=0x20 for 2 cycles, DmaAck pulses once, DmaRData unchanged.
REQ-038 Both Req high continuously for 4 grants -> fixed priority: CPU, CPU, CPU, CPU; with ARB_ROUND_ROBIN_EN: CPU, DMA, CPU, DMA.
REQ-039 Reset pulsed in 2nd ACCESS cycle of a CPU read -> MemEn=0 immediately, no CpuAck, next CpuReq completes normally.
REQ-040 MEM_LAT=1, back-to-back CPU reads with Req held -> Ack every 3 cycles, never two consecutive Ack cycles.
